// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between NREQ requesters, with a
// one-deep registered response stage (valid/ready) and an accepted-op counter.
module alu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [NREQ-1:0]   req_iscmp,
  input  logic [32*NREQ-1:0] req_d0,
  input  logic [32*NREQ-1:0] req_d1,
  output logic [31:0]       alu_d0,
  output logic [31:0]       alu_d1,
  output logic [3:0]        alu_op,
  output logic              alu_iscmp,
  input  logic [31:0]       alu_dout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_id,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic [CNTW-1:0]   op_count
);

  localparam logic [0:0] EMPTY    = 1'b0;
  localparam logic [0:0] FULL     = 1'b1;
  localparam logic [2:0] LAST_RST = 3'(NREQ - 1);

  logic [0:0] state;
  logic [2:0] last;

  // Requester fields widened to the full 8-entry index space so a 3-bit index
  // selects them directly; unused lanes read as zero.
  logic [7:0]       vld8, cmp8;
  logic [7:0][3:0]  op8;
  logic [7:0][31:0] d0_8, d1_8;

  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_lane
      if (g < NREQ) begin : g_on
        assign vld8[g] = req_valid[g];
        assign cmp8[g] = req_iscmp[g];
        assign op8[g]  = req_op[4*g +: 4];
        assign d0_8[g] = req_d0[32*g +: 32];
        assign d1_8[g] = req_d1[32*g +: 32];
      end else begin : g_off
        assign vld8[g] = 1'b0;
        assign cmp8[g] = 1'b0;
        assign op8[g]  = '0;
        assign d0_8[g] = '0;
        assign d1_8[g] = '0;
      end
    end
  endgenerate

  logic       can_accept, found, grant;
  logic [2:0] gidx;
  logic [3:0] cand;

  assign can_accept = (state == EMPTY) || rsp_ready;

  // Search last+1, last+2, ... modulo NREQ; first valid index wins.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last} + 4'(k);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (!found && vld8[cand[2:0]]) begin
        found = 1'b1;
        gidx  = cand[2:0];
      end
    end
  end

  assign grant = can_accept && found && !reset;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = grant && (gidx == 3'(i));
  end

  assign alu_d0    = grant ? d0_8[gidx] : '0;
  assign alu_d1    = grant ? d1_8[gidx] : '0;
  assign alu_op    = grant ? op8[gidx]  : '0;
  assign alu_iscmp = grant ? cmp8[gidx] : 1'b0;

  logic unused_op;
  always_comb begin
    unused_op = 1'b0;
    if (alu_iscmp) unused_op = alu_op[3];
    else           unused_op = alu_op inside {4'd3, 4'd6, 4'd7, [4'd10:4'd15]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_err  <= 1'b0;
      op_count <= '0;
      last     <= LAST_RST;
    end else if (grant) begin
      state    <= FULL;
      rsp_data <= alu_dout;
      rsp_id   <= gidx;
      rsp_err  <= unused_op;
      last     <= gidx;
      op_count <= op_count + CNTW'(1);
    end else if (rsp_ready) begin
      state    <= EMPTY;
    end
  end

  assign rsp_valid = (state == FULL);

endmodule
